// File: rtl/result_uart_tx.sv
// result_uart_tx: captures a bank-compare result on a rising edge of
// transmit_ready and sends it to the host as a 4-byte UART 8N1 packet:
// HEADER, {match, 000, index[11:8]}, index[7:0], XOR checksum.
module result_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 347,
  parameter logic [7:0]  HEADER       = 8'hA5,
  parameter int unsigned INDEX_W      = 12
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               transmit_ready,
  input  logic               result_compare,
  input  logic [INDEX_W-1:0] final_index,
  output logic               tx,
  output logic               busy,
  output logic               done,
  output logic               overrun
);

  localparam int unsigned CNT_W = 12;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_baud;
  logic [2:0]       r_bit_idx;
  logic [1:0]       r_byte_idx;
  logic [31:0]      r_pkt;
  logic             r_tr_q;
  logic             r_tx;
  logic             r_busy;
  logic             r_done;
  logic             r_overrun;
  logic             r_fin;

  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_baud_nxt;
  logic [2:0]       w_bit_nxt;
  logic [1:0]       w_byte_nxt;
  logic             w_fin_nxt;
  logic             w_tx_nxt;
  logic             w_req;
  logic             w_capture;
  logic             w_baud_end;
  logic [7:0]       w_b1;
  logic [7:0]       w_b2;
  logic [7:0]       w_b3;
  logic [7:0]       w_cur_byte;

  // Rising-edge request detect and packet byte assembly
  assign w_req      = transmit_ready & ~r_tr_q;
  assign w_capture  = w_req & (r_state == S_IDLE);
  assign w_baud_end = (r_baud == BAUD_LAST);
  assign w_b1       = {result_compare, 3'b000, final_index[11:8]};
  assign w_b2       = final_index[7:0];
  assign w_b3       = HEADER ^ w_b1 ^ w_b2;

  // Select the byte currently being shifted out
  always_comb begin
    w_cur_byte = r_pkt[7:0];
    case (r_byte_idx)
      2'd0:    w_cur_byte = r_pkt[7:0];
      2'd1:    w_cur_byte = r_pkt[15:8];
      2'd2:    w_cur_byte = r_pkt[23:16];
      default: w_cur_byte = r_pkt[31:24];
    endcase
  end

  // Next-state, counter and line-level logic
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = w_baud_end ? '0 : r_baud + CNT_W'(1);
    w_bit_nxt   = r_bit_idx;
    w_byte_nxt  = r_byte_idx;
    w_fin_nxt   = 1'b0;
    w_tx_nxt    = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        if (w_capture) begin
          w_state_nxt = S_START;
          w_bit_nxt   = 3'd0;
          w_byte_nxt  = 2'd0;
        end
      end
      S_START: begin
        w_tx_nxt = 1'b0;
        if (w_baud_end) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = 3'd0;
        end
      end
      S_DATA: begin
        w_tx_nxt = w_cur_byte[r_bit_idx];
        if (w_baud_end) begin
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_baud_end) begin
          if (r_byte_idx != 2'd3) begin
            w_byte_nxt  = r_byte_idx + 2'd1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
            w_fin_nxt   = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_baud_nxt  = '0;
      end
    endcase
  end

  // FSM state and bit/byte counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bit_idx  <= 3'd0;
      r_byte_idx <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud     <= w_baud_nxt;
      r_bit_idx  <= w_bit_nxt;
      r_byte_idx <= w_byte_nxt;
    end
  end

  // Packet latch, request history and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pkt     <= '0;
      r_tr_q    <= 1'b1;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_fin     <= 1'b0;
    end else begin
      r_tr_q <= transmit_ready;
      r_tx   <= w_tx_nxt;
      r_fin  <= w_fin_nxt;
      r_done <= r_fin;
      if (w_capture) begin
        r_pkt     <= {w_b3, w_b2, w_b1, HEADER};
        r_busy    <= 1'b1;
        r_overrun <= 1'b0;
      end else begin
        if (r_fin) begin
          r_busy <= 1'b0;
        end
        if (w_req) begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  assign tx      = r_tx;
  assign busy    = r_busy;
  assign done    = r_done;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx with CLKS_PER_BIT=4.
module tb_result_uart_tx;

  localparam int unsigned CPB = 4;
  localparam int PKT = 40 * CPB;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        transmit_ready;
  logic        result_compare;
  logic [11:0] final_index;
  logic        tx;
  logic        busy;
  logic        done;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  result_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .HEADER      (8'hA5),
    .INDEX_W     (12)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .transmit_ready(transmit_ready),
    .result_compare(result_compare),
    .final_index   (final_index),
    .tx            (tx),
    .busy          (busy),
    .done          (done),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected line level in cycle k (1-based) after the capture edge
  function automatic logic exp_tx(input int k, input logic [31:0] pk);
    int p;
    int b;
    logic [7:0] by;
    p  = (k - 1) / CPB;
    b  = p % 10;
    by = pk[8*(p/10) +: 8];
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return by[b-1];
  endfunction

  // Raise a request; returns just after the capture edge
  task automatic start_req(input logic rc, input logic [11:0] idx);
    result_compare = rc;
    final_index    = idx;
    transmit_ready = 1'b1;
    tick();
  endtask

  // Follow one packet from just after its capture edge through done
  task automatic run_packet(input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3,
                            input bit hold, input int req2_at, input bit chain,
                            input logic nrc, input logic [11:0] nidx);
    int txbad;
    int busybad;
    int donebad;
    logic [31:0] pk;
    logic [31:0] rec;
    int p;
    int b;
    txbad   = 0;
    busybad = 0;
    donebad = 0;
    rec     = '0;
    pk      = {e3, e2, e1, e0};
    chk1("cap_busy", busy, 1'b1);
    chk1("cap_tx_idle", tx, 1'b1);
    chk1("cap_ovr_clear", overrun, 1'b0);
    for (int k = 1; k <= PKT; k++) begin
      tick();
      if (k == 1) begin
        if (!hold) transmit_ready = 1'b0;
        result_compare = ~result_compare;
        final_index    = ~final_index;
      end
      if (req2_at != 0) begin
        if (k == req2_at - 1) begin
          chk1("ovr_before", overrun, 1'b0);
          transmit_ready = 1'b1;
        end
        if (k == req2_at) chk1("ovr_set", overrun, 1'b1);
        if (k == req2_at + 1) transmit_ready = 1'b0;
      end
      if (chain && k == PKT) begin
        result_compare = nrc;
        final_index    = nidx;
        transmit_ready = 1'b1;
      end
      if (tx !== exp_tx(k, pk)) txbad++;
      if (busy !== 1'b1) busybad++;
      if (done !== 1'b0) donebad++;
      p = (k - 1) / CPB;
      b = p % 10;
      if (((k - 1) % CPB) == CPB / 2 && b >= 1 && b <= 8) rec[8*(p/10) + b - 1] = tx;
    end
    chkn("tx_wave_mismatches", txbad, 0);
    chkn("busy_low_in_packet", busybad, 0);
    chkn("early_done", donebad, 0);
    chk8("byte0", rec[7:0], e0);
    chk8("byte1", rec[15:8], e1);
    chk8("byte2", rec[23:16], e2);
    chk8("byte3", rec[31:24], e3);
    tick();
    chk1("done_pulse", done, 1'b1);
    chk1("busy_at_done", busy, chain ? 1'b1 : 1'b0);
    if (!chain) begin
      tick();
      chk1("done_one_cycle", done, 1'b0);
      chk1("busy_after", busy, 1'b0);
      chk1("tx_idle_after", tx, 1'b1);
    end
  endtask

  initial begin
    int bad;
    reset_n        = 1'b0;
    transmit_ready = 1'b0;
    result_compare = 1'b0;
    final_index    = 12'h000;
    #12;
    chk1("rst_tx", tx, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_ovr", overrun, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk1("idle_busy", busy, 1'b0);

    // Match class 1, index 3A7
    start_req(1'b1, 12'h3A7);
    run_packet(8'hA5, 8'h83, 8'hA7, 8'h81, 1'b0, 0, 1'b0, 1'b0, 12'h000);

    // Match class 0, all-ones index
    tick();
    start_req(1'b0, 12'hFFF);
    run_packet(8'hA5, 8'h0F, 8'hFF, 8'h55, 1'b0, 0, 1'b0, 1'b0, 12'h000);

    // Second request while busy: dropped, overrun sticky until next capture
    tick();
    start_req(1'b1, 12'h3A7);
    run_packet(8'hA5, 8'h83, 8'hA7, 8'h81, 1'b0, 50, 1'b0, 1'b0, 12'h000);
    repeat (5) tick();
    chk1("no_queued_packet", busy, 1'b0);
    chk1("ovr_sticky", overrun, 1'b1);
    start_req(1'b0, 12'h001);
    run_packet(8'hA5, 8'h00, 8'h01, 8'hA4, 1'b0, 0, 1'b0, 1'b0, 12'h000);

    // Level held high for 500 cycles yields a single packet
    tick();
    start_req(1'b1, 12'h800);
    run_packet(8'hA5, 8'h88, 8'h00, 8'h2D, 1'b1, 0, 1'b0, 1'b0, 12'h000);
    bad = 0;
    for (int i = 0; i < 500 - PKT - 2; i++) begin
      tick();
      if (busy !== 1'b0 || done !== 1'b0) bad++;
    end
    chkn("held_high_single", bad, 0);
    transmit_ready = 1'b0;
    tick();
    start_req(1'b0, 12'h123);
    run_packet(8'hA5, 8'h01, 8'h23, 8'h87, 1'b0, 0, 1'b0, 1'b0, 12'h000);

    // Reset mid-packet with transmit_ready held high through release
    tick();
    start_req(1'b1, 12'h055);
    repeat (69) tick();
    chk1("pre_reset_busy", busy, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk1("midrst_tx", tx, 1'b1);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_done", done, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (busy !== 1'b0 || done !== 1'b0 || tx !== 1'b1) bad++;
    end
    chkn("no_packet_after_reset", bad, 0);

    // Request on the done edge chains packets back to back
    transmit_ready = 1'b0;
    tick();
    start_req(1'b1, 12'hABC);
    run_packet(8'hA5, 8'h8A, 8'hBC, 8'h93, 1'b0, 0, 1'b1, 1'b0, 12'h5F0);
    run_packet(8'hA5, 8'h05, 8'hF0, 8'h50, 1'b0, 0, 1'b0, 1'b0, 12'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
- Consumer end of the bank-compare result interface. The comparator raises transmit_ready when correlation finishes; this block then captures result_compare and final_index.
- It serialises them as a 4-byte framed packet over UART 8N1 to the host.
- Sits between the correlation/compare stage and the off-chip tx pin.
- It is the only path by which match results leave the FPGA.

Parameters:
- CLKS_PER_BIT, 347, clock cycles per UART bit (40 MHz / 115200); legal range 2..4095.
- HEADER, 8'hA5, first byte of every packet.
- INDEX_W, 12, width of final_index; fixed at 12 for this packet format.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- transmit_ready  input  1  level from the compare stage; a rising edge requests one packet.
- result_compare  input  1  match class (1 = stop, 0 = cat); valid while transmit_ready is high.
- final_index  input  INDEX_W  lag index of the best correlation; valid while transmit_ready is high.
- tx  output  1  UART serial line; idles high.
- busy  output  1  high while a packet is in flight.
- done  output  1  one-cycle pulse when a packet completes.
- overrun  output  1  sticky; a request arrived while busy.

Behaviour:
- Reset (asynchronous, immediate): tx=1, busy=0, done=0, overrun=0, FSM=IDLE, all counters 0.
- Reset also sets the transmit_ready history register to 1, so a level held high across reset does not start a packet.
- Request detect: req = transmit_ready & ~tr_q, where tr_q is transmit_ready registered every cycle.
- Capture, at clock edge C where req=1 and FSM=IDLE:
  - Latch b0=HEADER.
  - Latch b1={result_compare, 3'b000, final_index[11:8]}.
  - Latch b2=final_index[7:0].
  - Latch b3=b0^b1^b2.
  - Set busy=1 and clear overrun.
  - Later input changes do not affect the packet.
- FSM states IDLE, START, DATA, STOP:
  - IDLE -> START on capture.
  - START: tx=0 for CLKS_PER_BIT cycles, then -> DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles, then -> STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If byte_idx<3, increment byte_idx and go to START with no idle gap; otherwise go to IDLE.
- tx is a registered output and is glitch-free.
- Timing for capture edge C:
  - The byte-0 start bit occupies cycles C+1..C+CLKS_PER_BIT.
  - The packet is 40 bit periods long, ending at cycle C+40*CLKS_PER_BIT.
  - In cycle C+40*CLKS_PER_BIT+1: done=1 for that one cycle, busy=0, FSM=IDLE.
- Bit counter is 0..7; byte index is 0..3.
- The baud counter wraps to 0 at CLKS_PER_BIT-1 and restarts on every bit boundary.
- Request while busy: the packet in flight is unaffected, the request is dropped (not queued), and overrun=1 from the next cycle.
- overrun stays set until the next accepted capture or reset.
- Request in the same cycle done is asserted: FSM is already IDLE, so the request is accepted. The capture occurs on that edge and busy stays 1.
- transmit_ready held high: only one packet is sent. A new packet requires transmit_ready to go low for at least one cycle and then high again.
- Reset mid-packet: tx goes high immediately; the partial frame is abandoned and no done pulse is produced.

Test Plan:
1. CLKS_PER_BIT=4; result_compare=1, final_index=12'h3A7, pulse transmit_ready -> tx bytes A5, 83, A7, 81 (LSB first, 8N1). done is high at C+161 only, and busy is high over C..C+160.
2. result_compare=0, final_index=12'hFFF -> bytes A5, 0F, FF, 55; the checksum matches the XOR of the three bytes.
3. Second rising edge of transmit_ready at C+50 -> the packet from scenario 1 is unchanged, overrun=1 from C+51, and no second packet is sent. The next accepted request clears overrun.
4. transmit_ready held high for 500 cycles -> exactly one packet. Low for 1 cycle, then high -> a second packet starts on the rising edge.
5. reset_n asserted at C+70 -> tx=1, busy=0 in the same cycle with no done pulse. Holding transmit_ready high through reset release produces no packet.
6. New request in the done cycle -> back-to-back packets with no gap longer than one cycle; done pulses once per packet.
